// File: rtl/posit_pkg.sv
// posit_pkg: posit8 constants and the dot-product sequencer state type.
// Shared by the sequencer and anything that talks to the posit MAC.
package posit_pkg;

   localparam int POSIT_W = 8;

   localparam logic [POSIT_W-1:0] POSIT_ZERO = 8'h00;
   localparam logic [POSIT_W-1:0] POSIT_NAR  = 8'h80;

   // default register stages between mac_* and mac_res
   localparam int DEF_MAC_LAT = 2;

   typedef enum logic [1:0] {
      IDLE,
      ACCEPT,
      WAIT,
      DONE
   } dot_state_t;

endpackage

// File: rtl/posit_dot_seq.sv
// posit_dot_seq: feeds operand pairs to a registered posit8 MAC,
// folds each result into an accumulator and emits the dot product.
module posit_dot_seq
   import posit_pkg::*;
#(
   parameter int MAC_LAT = DEF_MAC_LAT,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [POSIT_W-1:0] in_a,
   input  logic [POSIT_W-1:0] in_b,
   input  logic               in_last,
   output logic [POSIT_W-1:0] mac_a,
   output logic [POSIT_W-1:0] mac_b,
   output logic [POSIT_W-1:0] mac_c,
   input  logic [POSIT_W-1:0] mac_res,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [POSIT_W-1:0] out_data,
   output logic [CNT_W-1:0]   out_count,
   output logic               out_nar
);

   localparam int WCNT_W = $clog2(MAC_LAT + 1) + 1;

   dot_state_t         state_q;
   dot_state_t         state_d;
   logic [POSIT_W-1:0] acc;
   logic [CNT_W-1:0]   cnt;
   logic [WCNT_W-1:0]  wcnt;
   logic               last_q;
   logic               in_fire;
   logic               wait_done;
   logic               out_fire;

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign wait_done = (state_q == WAIT) &&
                      (wcnt == WCNT_W'(MAC_LAT));

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next state plus handshake and result outputs
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = POSIT_ZERO;
      out_count = '0;
      out_nar   = 1'b0;
      unique case (state_q)
         IDLE: state_d = ACCEPT;
         ACCEPT: begin
            in_ready = 1'b1;
            if (in_valid) state_d = WAIT;
         end
         WAIT: begin
            if (wait_done)
               state_d = last_q ? DONE : ACCEPT;
         end
         DONE: begin
            out_valid = 1'b1;
            out_data  = acc;
            out_count = cnt;
            out_nar   = (acc == POSIT_NAR);
            if (out_ready) state_d = ACCEPT;
         end
         default: state_d = IDLE;
      endcase
   end

   // operand issue, latency wait, accumulate and term count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mac_a  <= POSIT_ZERO;
         mac_b  <= POSIT_ZERO;
         mac_c  <= POSIT_ZERO;
         acc    <= POSIT_ZERO;
         cnt    <= '0;
         wcnt   <= '0;
         last_q <= 1'b0;
      end else begin
         if (in_fire) begin
            mac_a  <= in_a;
            mac_b  <= in_b;
            mac_c  <= acc;
            last_q <= in_last;
            wcnt   <= '0;
            if (cnt != '1) cnt <= cnt + CNT_W'(1);
         end
         if (state_q == WAIT) wcnt <= wcnt + WCNT_W'(1);
         if (wait_done) acc <= mac_res;
         if (out_fire) begin
            acc <= POSIT_ZERO;
            cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_posit_dot_seq.sv
// tb_posit_dot_seq: drives posit8 pairs through the sequencer with a
// behavioural posit8 MAC beside it and checks dot products.
module tb_posit_dot_seq;

   localparam int LAT = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       in_last;
   logic [7:0] mac_a;
   logic [7:0] mac_b;
   logic [7:0] mac_c;
   logic [7:0] mac_res;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [7:0] out_count;
   logic       out_nar;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   assign rst_n = ~rst;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   posit_dot_seq #(
      .MAC_LAT(LAT),
      .CNT_W  (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_last  (in_last),
      .mac_a    (mac_a),
      .mac_b    (mac_b),
      .mac_c    (mac_c),
      .mac_res  (mac_res),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_count(out_count),
      .out_nar  (out_nar)
   );

   // posit8 (es=0) pattern to real value
   function automatic real dec(input logic [7:0] p);
      logic [7:0] v;
      logic       r;
      int         m;
      int         k;
      int         nf;
      real        f;
      real        s;
      if (p == 8'h00) return 0.0;
      v = p[7] ? 8'(-p) : p;
      r = v[6];
      m = 0;
      while (m < 7 && v[6-m] == r) m++;
      k  = r ? m - 1 : -m;
      nf = 6 - m;
      if (nf < 0) nf = 0;
      f = 1.0 + real'(int'(v) & ((1 << nf) - 1)) / real'(1 << nf);
      s = 1.0;
      if (k >= 0) repeat (k) s = s * 2.0;
      else        repeat (-k) s = s / 2.0;
      return p[7] ? -(f * s) : f * s;
   endfunction

   // nearest posit8 to x, ties to even pattern, never to zero/NaR
   function automatic logic [7:0] enc(input real x);
      logic [7:0] best;
      real        bd;
      real        d;
      if (x == 0.0) return 8'h00;
      best = 8'h01;
      bd   = -1.0;
      for (int i = 1; i < 256; i++) begin
         if (i != 128) begin
            d = x - dec(8'(i));
            if (d < 0.0) d = -d;
            if (bd < 0.0 || d < bd || (d == bd && i % 2 == 0)) begin
               bd   = d;
               best = 8'(i);
            end
         end
      end
      return best;
   endfunction

   function automatic logic [7:0] mac_f(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic [7:0] c);
      if (a == 8'h80 || b == 8'h80 || c == 8'h80) return 8'h80;
      return enc(dec(a) * dec(b) + dec(c));
   endfunction

   // behavioural two-stage posit MAC
   logic [7:0] ma, mb, mc;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma <= 8'h00; mb <= 8'h00; mc <= 8'h00;
         mac_res <= 8'h00;
      end else begin
         ma <= mac_a; mb <= mac_b; mc <= mac_c;
         mac_res <= mac_f(ma, mb, mc);
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // call at a negedge; returns at the negedge after the handshake
   task automatic send(input logic [7:0] a, input logic [7:0] b,
                       input logic last, output int hs);
      int n;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", 32'(in_ready), 32'd1);
      hs = cyc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
   endtask

   task automatic get_result(input string tag, input logic [7:0] ed,
                             input int ecnt, input int hs,
                             input int hold);
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_lat"}, 32'(cyc - hs), 32'(LAT + 2));
      check({tag, "_data"}, 32'(out_data), 32'(ed));
      check({tag, "_count"}, 32'(out_count), 32'(ecnt));
      check({tag, "_nar"}, 32'(out_nar), 32'(ed == 8'h80));
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int hs;
      int len;
      int k;
      int n;
      int prev;
      int gaps;
      logic [7:0] ea;
      logic [7:0] eb;
      logic [7:0] exp;
      logic [7:0] held;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = 8'h00;
      in_b      = 8'h00;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_count", 32'(out_count), 32'd0);
      check("rst_mac_a", 32'(mac_a), 32'd0);
      check("rst_mac_c", 32'(mac_c), 32'd0);
      rst = 1'b0;
      #1;
      check("idle_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("accept_ready", 32'(in_ready), 32'd1);

      send(8'h40, 8'h40, 1'b0, hs);
      send(8'h60, 8'h50, 1'b1, hs);
      get_result("dot2", 8'h70, 2, hs, 0);

      send(8'h40, 8'h40, 1'b0, hs);
      send(8'hC0, 8'h40, 1'b1, hs);
      get_result("signed", 8'h00, 2, hs, 1);

      send(8'h80, 8'h40, 1'b0, hs);
      send(8'h40, 8'h40, 1'b1, hs);
      get_result("nar", 8'h80, 2, hs, 0);

      send(8'h40, 8'h40, 1'b1, hs);
      while (!out_valid && cyc < hs + 20) @(negedge clk);
      held = out_data;
      check("bp_first", 32'(held), 32'h40);
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_a = 8'($urandom);
         in_b = 8'($urandom);
         @(negedge clk);
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_data", 32'(out_data), 32'(held));
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      send(8'h40, 8'h40, 1'b1, hs);
      get_result("bp_restart", 8'h40, 1, hs, 0);

      send(8'h40, 8'h40, 1'b0, hs);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("mrst_mac_a", 32'(mac_a), 32'd0);
      check("mrst_mac_b", 32'(mac_b), 32'd0);
      check("mrst_in_ready", 32'(in_ready), 32'd0);
      check("mrst_out_valid", 32'(out_valid), 32'd0);
      check("mrst_out_count", 32'(out_count), 32'd0);
      check("mrst_out_nar", 32'(out_nar), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mrst_idle", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("mrst_accept", 32'(in_ready), 32'd1);
      send(8'h60, 8'h40, 1'b1, hs);
      get_result("mrst_fresh", 8'h60, 1, hs, 0);

      for (int v = 0; v < 8; v++) begin
         len = int'($urandom_range(1, 5));
         exp = 8'h00;
         for (int j = 0; j < len; j++) begin
            ea  = 8'($urandom);
            eb  = 8'($urandom);
            exp = mac_f(ea, eb, exp);
            send(ea, eb, j == len - 1, hs);
         end
         get_result("rand", exp, len, hs,
                    int'($urandom_range(0, 3)));
      end

      in_valid = 1'b1;
      in_a = 8'h00;
      in_b = 8'h40;
      k = 0;
      n = 0;
      prev = -1;
      gaps = 0;
      while (k < 300 && n < 3000) begin
         in_last = (k == 299);
         if (in_ready) begin
            if (prev >= 0 && cyc - prev != LAT + 2) gaps++;
            prev = cyc;
            k++;
         end
         @(negedge clk);
         n++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("tp_pairs", 32'(k), 32'd300);
      check("tp_gaps", 32'(gaps), 32'd0);
      get_result("sat", 8'h00, 255, prev, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
